// File: rtl/lua_cpu_pkg.sv
// lua_cpu_pkg: widths and types shared across the Lua processor pipeline.
package lua_cpu_pkg;
   localparam int INST_W = 32;
   localparam int PC_W = 32;
   typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_t;
   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fifo_entry_t;
endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: synchronous prefetch FIFO; flush overrides push, pop still completes.
module inst_fifo
   import lua_cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fifo_entry_t              din,
   output fifo_entry_t              head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   fifo_entry_t mem [DEPTH];
   logic [AW-1:0] wr, rd;
   logic do_pop;
   assign do_pop = pop && count != '0;
   assign head = mem[rd];
   // storage is reset so the head never reads X while empty
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         mem <= '{default: '0};
         wr <= '0;
         rd <= '0;
         count <= '0;
      end else if (flush) begin
         wr <= '0;
         rd <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wr] <= din;
            wr <= wr + AW'(1);
         end
         if (do_pop) rd <= rd + AW'(1);
         count <= count + CW'(push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: PC owner and imem fetch FSM feeding a prefetch FIFO toward decode.
module ifetch_queue
   import lua_cpu_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     redirect_valid,
   input  logic [PC_W-1:0]          redirect_pc,
   output logic                     imem_req,
   output logic [PC_W-1:0]          imem_addr,
   input  logic                     imem_ack,
   input  logic [INST_W-1:0]        imem_rdata,
   output logic                     inst_valid,
   output logic [INST_W-1:0]        inst,
   output logic [PC_W-1:0]          inst_pc,
   input  logic                     inst_ready,
   output logic [$clog2(DEPTH):0]   fifo_count
);
   localparam int CW = $clog2(DEPTH) + 1;
   fetch_state_t state, state_nxt;
   logic [PC_W-1:0] fetch_pc, fetch_nxt;
   logic [CW-1:0] ncount;
   logic ack, push, pop, load;
   fifo_entry_t head;
   assign ack = state != IDLE && imem_ack;
   assign push = state == REQ && imem_ack && !redirect_valid;
   assign pop = inst_valid && inst_ready;
   assign ncount = fifo_count + CW'(1) - CW'(pop);
   assign inst_valid = fifo_count != '0;
   assign inst = head.inst;
   assign inst_pc = head.pc;
   // a new address is launched only when no request is left outstanding
   assign load = state_nxt == REQ && (state == IDLE || ack);
   always_comb begin
      state_nxt = state;
      fetch_nxt = fetch_pc;
      if (redirect_valid) begin
         state_nxt = (state != IDLE && !imem_ack) ? DROP : REQ;
         fetch_nxt = redirect_pc;
      end else if (state == IDLE) begin
         state_nxt = fifo_count < CW'(DEPTH) ? REQ : IDLE;
      end else if (ack) begin
         state_nxt = (state == DROP || ncount < CW'(DEPTH)) ? REQ : IDLE;
         fetch_nxt = state == REQ ? fetch_pc + PC_W'(1) : fetch_pc;
      end
   end
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= IDLE;
         fetch_pc <= RESET_PC;
         imem_addr <= RESET_PC;
         imem_req <= 1'b0;
      end else begin
         state <= state_nxt;
         fetch_pc <= fetch_nxt;
         imem_req <= state_nxt != IDLE;
         if (load) imem_addr <= fetch_nxt;
      end
   end
   inst_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .n_reset (n_reset),
      .push    (push),
      .pop     (pop),
      .flush   (redirect_valid),
      .din     ('{pc: fetch_pc, inst: imem_rdata}),
      .head    (head),
      .count   (fifo_count)
   );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed vector table plus corner sequences for ifetch_queue.
module tb_ifetch_queue;
   logic clk = 0, n_reset = 1, redirect_valid = 0, imem_ack = 0, inst_ready = 0;
   logic imem_req, inst_valid;
   logic [31:0] redirect_pc = 0, imem_addr, imem_rdata = 0, inst, inst_pc;
   logic [2:0] fifo_count;
   logic [31:0] last_ack_addr = 0;
   int checks = 0, errors = 0, lat = 0, waitc = 0, ack_cnt = 0;

   typedef struct {
      logic ready, redir;
      logic [31:0] rpc;
      logic req;
      logic [31:0] addr;
      logic valid;
      logic [31:0] pc, ins;
      logic [2:0] cnt;
   } vec_t;
   vec_t tbl [16];

   always #5 clk = ~clk;

   ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .n_reset(n_reset), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
      .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready), .fifo_count(fifo_count)
   );

   // memory model: acks after lat wait cycles, rdata = addr + 0x100
   always @(negedge clk) begin
      if (!n_reset || !imem_req) begin
         imem_ack = 0;
         waitc = 0;
         if (!n_reset) ack_cnt = 0;
      end else if (waitc >= lat) begin
         imem_ack = 1;
         imem_rdata = imem_addr + 32'h100;
         last_ack_addr = imem_addr;
         waitc = 0;
         ack_cnt++;
      end else begin
         imem_ack = 0;
         waitc++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      //           ready redir rpc            req addr          valid pc            inst          cnt
      tbl[0]  = '{1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        3'd0};
      tbl[1]  = '{1, 0, 32'h0,        1, 32'h1,        1, 32'h0,        32'h100,      3'd1};
      tbl[2]  = '{1, 0, 32'h0,        1, 32'h2,        1, 32'h1,        32'h101,      3'd1};
      tbl[3]  = '{1, 0, 32'h0,        1, 32'h3,        1, 32'h2,        32'h102,      3'd1};
      tbl[4]  = '{0, 0, 32'h0,        1, 32'h4,        1, 32'h2,        32'h102,      3'd2};
      tbl[5]  = '{0, 0, 32'h0,        1, 32'h5,        1, 32'h2,        32'h102,      3'd3};
      tbl[6]  = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h2,        32'h102,      3'd4};
      tbl[7]  = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h2,        32'h102,      3'd4};
      tbl[8]  = '{1, 0, 32'h0,        0, 32'h0,        1, 32'h3,        32'h103,      3'd3};
      tbl[9]  = '{0, 0, 32'h0,        1, 32'h6,        1, 32'h3,        32'h103,      3'd3};
      tbl[10] = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h3,        32'h103,      3'd4};
      tbl[11] = '{0, 1, 32'h40,       1, 32'h40,       0, 32'h0,        32'h0,        3'd0};
      tbl[12] = '{1, 0, 32'h0,        1, 32'h41,       1, 32'h40,       32'h140,      3'd1};
      tbl[13] = '{1, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 32'h0,      32'h0,        3'd0};
      tbl[14] = '{1, 0, 32'h0,        1, 32'h0,        1, 32'hFFFF_FFFF, 32'h0000_00FF, 3'd1};
      tbl[15] = '{1, 0, 32'h0,        1, 32'h1,        1, 32'h0,        32'h100,      3'd1};

      #1 n_reset = 0;
      repeat (2) @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(inst_valid), 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_pc", inst_pc, 32'h0);
      chk("rst_cnt", 32'(fifo_count), 32'h0);
      n_reset = 1;

      for (int i = 0; i < 16; i++) begin
         inst_ready = tbl[i].ready;
         redirect_valid = tbl[i].redir;
         redirect_pc = tbl[i].rpc;
         @(negedge clk);
         chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
         if (tbl[i].req) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
         chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(tbl[i].valid));
         if (tbl[i].valid) begin
            chk($sformatf("v%0d_pc", i), inst_pc, tbl[i].pc);
            chk($sformatf("v%0d_inst", i), inst, tbl[i].ins);
         end
         chk($sformatf("v%0d_cnt", i), 32'(fifo_count), 32'(tbl[i].cnt));
      end
      redirect_valid = 0;
      inst_ready = 0;

      // asynchronous reset mid-operation
      #2 n_reset = 0;
      #1;
      chk("areset_req", 32'(imem_req), 32'h0);
      chk("areset_addr", imem_addr, 32'h0);
      chk("areset_cnt", 32'(fifo_count), 32'h0);
      chk("areset_inst", inst, 32'h0);
      chk("areset_pc", inst_pc, 32'h0);

      // 3-cycle latency memory, decode stalled
      @(negedge clk);
      lat = 3;
      @(negedge clk);
      n_reset = 1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk($sformatf("lat%0d_req", k), 32'(imem_req), 32'h1);
         chk($sformatf("lat%0d_addr", k), imem_addr, 32'((k - 1) / 4));
         chk($sformatf("lat%0d_cnt", k), 32'(fifo_count), 32'((k - 1) / 4));
         if (k >= 5) chk($sformatf("lat%0d_head", k), inst_pc, 32'h0);
      end
      // redirect while the addr-2 request waits for ack
      redirect_valid = 1;
      redirect_pc = 32'h40;
      @(negedge clk);
      redirect_valid = 0;
      chk("drop_req", 32'(imem_req), 32'h1);
      chk("drop_addr_hold", imem_addr, 32'h2);
      chk("drop_cnt", 32'(fifo_count), 32'h0);
      @(negedge clk);
      chk("drop_addr_hold2", imem_addr, 32'h2);
      @(negedge clk);
      chk("drop_next_addr", imem_addr, 32'h40);
      chk("drop_discard", 32'(inst_valid), 32'h0);
      begin
         int n = 0;
         while (!inst_valid && n < 10) begin
            @(negedge clk);
            n++;
         end
         chk("drop_first_valid", 32'(inst_valid), 32'h1);
         chk("drop_first_pc", inst_pc, 32'h40);
         chk("drop_first_inst", inst, 32'h140);
      end

      // full queue from empty, zero-wait memory
      n_reset = 0;
      lat = 0;
      @(negedge clk);
      @(negedge clk);
      n_reset = 1;
      repeat (10) @(negedge clk);
      chk("full_acks", 32'(ack_cnt), 32'd4);
      chk("full_cnt", 32'(fifo_count), 32'd4);
      chk("full_req", 32'(imem_req), 32'h0);
      inst_ready = 1;
      @(negedge clk);
      inst_ready = 0;
      repeat (4) @(negedge clk);
      chk("refill_acks", 32'(ack_cnt), 32'd5);
      chk("refill_addr", last_ack_addr, 32'h4);
      chk("refill_cnt", 32'(fifo_count), 32'd4);
      chk("refill_req", 32'(imem_req), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
